// File: rtl/revo_phase_calibration_controller.sv
// Revo delay-tap calibration: sweeps taps, qualifies revo period per tap, centres on longest good window; tracks PLL lock.
// Latency: registered outputs, 1 cycle after the deciding edge; EVAL is a single cycle per tap.
// No backpressure: start is ignored while busy. Optional DONE-state slip monitor: REVO_CALIBRATION_CONTINUOUS_MONITOR_EN.
module revo_phase_calibration_controller #(
    parameter int TAP_WIDTH          = 5,
    parameter int NUM_TAPS           = 32,
    parameter int SETTLE_CYCLES      = 64,
    parameter int PULSES_PER_TAP     = 8,
    parameter int EXPECTED_PERIOD    = 1280,
    parameter int PERIOD_WIDTH       = 16,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MIN_GOOD_TAPS      = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 pll_locked,
    input  logic                 revo_pulse,
    output logic [TAP_WIDTH-1:0] delay_tap,
    output logic                 clock_select,
    output logic                 busy,
    output logic                 calibrated,
    output logic                 error,
    output logic [TAP_WIDTH-1:0] best_start,
    output logic [TAP_WIDTH:0]   best_length,
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
    output logic                 revo_slip,
`endif
    output logic [7:0]           lock_loss_count
);

    localparam int LW  = TAP_WIDTH + 1;
    localparam int LCW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int PCW = $clog2(PULSES_PER_TAP + 1);

    localparam logic [PERIOD_WIDTH-1:0] EXP_P        = PERIOD_WIDTH'(EXPECTED_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_LAST = PERIOD_WIDTH'(2 * EXPECTED_PERIOD - 1);
    localparam logic [LCW-1:0]          LOCK_LAST    = LCW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SCW-1:0]          SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
    localparam logic [PCW-1:0]          PULSE_LAST   = PCW'(PULSES_PER_TAP - 1);
    localparam logic [TAP_WIDTH-1:0]    LAST_TAP     = TAP_WIDTH'(NUM_TAPS - 1);
    localparam logic [LW-1:0]           MIN_LEN      = LW'(MIN_GOOD_TAPS);

    typedef enum logic [2:0] {
        IDLE, WAIT_LOCK, SETTLE, MEASURE, EVAL, DONE, FAIL
    } state_t;

    state_t                  state;
    logic [LCW-1:0]          lock_count;
    logic [SCW-1:0]          settle_count;
    logic [PCW-1:0]          pulse_count;
    logic [PERIOD_WIDTH-1:0] period_count;
    logic                    armed;
    logic                    tap_bad;
    logic [TAP_WIDTH-1:0]    run_start;
    logic [LW-1:0]           run_length;
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
    logic [1:0]              slip_count;
    logic                    bad_period;
    logic                    good_period;
`endif

    logic                 tap_good;
    logic                 last_tap;
    logic                 close_run;
    logic                 lock_lost;
    logic [LW-1:0]        run_len_inc;
    logic [LW-1:0]        cand_len;
    logic [TAP_WIDTH-1:0] cand_start;
    logic [LW-1:0]        new_best_len;
    logic [TAP_WIDTH-1:0] new_best_start;
    logic [TAP_WIDTH-1:0] centre_tap;

    // Run/best bookkeeping for the tap being evaluated; the last tap always closes its run.
    always_comb begin
        tap_good       = !tap_bad;
        last_tap       = (delay_tap == LAST_TAP);
        close_run      = !tap_good || last_tap;
        run_len_inc    = run_length + 1'b1;
        cand_len       = tap_good ? run_len_inc : run_length;
        cand_start     = (tap_good && run_length == '0) ? delay_tap : run_start;
        new_best_len   = best_length;
        new_best_start = best_start;
        if (close_run && cand_len > best_length) begin
            new_best_len   = cand_len;
            new_best_start = cand_start;
        end
        centre_tap = new_best_start + TAP_WIDTH'((new_best_len - 1'b1) >> 1);
        lock_lost  = !pll_locked &&
                     (state == SETTLE || state == MEASURE || state == EVAL || state == DONE);
    end

`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
    always_comb begin
        good_period = revo_pulse && armed && (period_count == EXP_P);
        bad_period  = (revo_pulse && armed && (period_count != EXP_P)) ||
                      (!revo_pulse && (period_count == TIMEOUT_LAST));
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= IDLE;
            delay_tap       <= '0;
            clock_select    <= 1'b1;
            busy            <= 1'b0;
            calibrated      <= 1'b0;
            error           <= 1'b0;
            best_start      <= '0;
            best_length     <= '0;
            lock_loss_count <= '0;
            lock_count      <= '0;
            settle_count    <= '0;
            pulse_count     <= '0;
            period_count    <= '0;
            armed           <= 1'b0;
            tap_bad         <= 1'b0;
            run_start       <= '0;
            run_length      <= '0;
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
            slip_count      <= '0;
            revo_slip       <= 1'b0;
`endif
        end else begin
            clock_select <= ~pll_locked;
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
            revo_slip    <= 1'b0;
`endif
            if (lock_lost) begin
                if (lock_loss_count != 8'hFF)
                    lock_loss_count <= lock_loss_count + 8'd1;
                calibrated <= 1'b0;
                busy       <= 1'b1;
                lock_count <= '0;
                state      <= WAIT_LOCK;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            lock_count <= '0;
                            busy       <= 1'b1;
                            state      <= WAIT_LOCK;
                        end
                    end
                    WAIT_LOCK: begin
                        if (!pll_locked) begin
                            lock_count <= '0;
                        end else if (lock_count == LOCK_LAST) begin
                            lock_count   <= '0;
                            delay_tap    <= '0;
                            run_start    <= '0;
                            run_length   <= '0;
                            best_start   <= '0;
                            best_length  <= '0;
                            settle_count <= '0;
                            state        <= SETTLE;
                        end else begin
                            lock_count <= lock_count + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (settle_count == SETTLE_LAST) begin
                            settle_count <= '0;
                            period_count <= '0;
                            pulse_count  <= '0;
                            armed        <= 1'b0;
                            tap_bad      <= 1'b0;
                            state        <= MEASURE;
                        end else begin
                            settle_count <= settle_count + 1'b1;
                        end
                    end
                    MEASURE: begin
                        // The arming pulse only starts the period counter.
                        if (revo_pulse) begin
                            period_count <= PERIOD_WIDTH'(1);
                            if (!armed) begin
                                armed <= 1'b1;
                            end else begin
                                if (period_count != EXP_P)
                                    tap_bad <= 1'b1;
                                pulse_count <= pulse_count + 1'b1;
                                if (pulse_count == PULSE_LAST)
                                    state <= EVAL;
                            end
                        end else if (period_count == TIMEOUT_LAST) begin
                            tap_bad <= 1'b1;
                            state   <= EVAL;
                        end else begin
                            period_count <= period_count + 1'b1;
                        end
                    end
                    EVAL: begin
                        best_length <= new_best_len;
                        best_start  <= new_best_start;
                        run_length  <= close_run ? '0 : run_len_inc;
                        run_start   <= cand_start;
                        if (!last_tap) begin
                            delay_tap    <= delay_tap + 1'b1;
                            settle_count <= '0;
                            state        <= SETTLE;
                        end else if (new_best_len >= MIN_LEN) begin
                            delay_tap    <= centre_tap;
                            busy         <= 1'b0;
                            calibrated   <= 1'b1;
                            period_count <= '0;
                            armed        <= 1'b0;
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
                            slip_count   <= '0;
`endif
                            state        <= DONE;
                        end else begin
                            delay_tap <= '0;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            state     <= FAIL;
                        end
                    end
                    DONE: begin
                        if (start) begin
                            calibrated <= 1'b0;
                            busy       <= 1'b1;
                            lock_count <= '0;
                            state      <= WAIT_LOCK;
                        end
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
                        else begin
                            if (revo_pulse) begin
                                period_count <= PERIOD_WIDTH'(1);
                                armed        <= 1'b1;
                            end else if (period_count == TIMEOUT_LAST) begin
                                period_count <= '0;
                            end else begin
                                period_count <= period_count + 1'b1;
                            end
                            // Four bad periods in a row means the chosen tap has slipped.
                            if (bad_period && slip_count == 2'd3) begin
                                slip_count <= '0;
                                revo_slip  <= 1'b1;
                                calibrated <= 1'b0;
                                busy       <= 1'b1;
                                lock_count <= '0;
                                state      <= WAIT_LOCK;
                            end else if (bad_period) begin
                                slip_count <= slip_count + 1'b1;
                            end else if (good_period) begin
                                slip_count <= '0;
                            end
                        end
`endif
                    end
                    FAIL: begin
                        if (start) begin
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            lock_count <= '0;
                            state      <= WAIT_LOCK;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_revo_phase_calibration_controller.sv
// Directed bench for revo_phase_calibration_controller with shortened timing parameters.
// Good taps see revo period 8, bad taps period 9; timeout is 16 cycles.
module tb_revo_phase_calibration_controller;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       pll_locked;
    logic       revo_pulse;
    logic [4:0] delay_tap;
    logic       clock_select;
    logic       busy;
    logic       calibrated;
    logic       error;
    logic [4:0] best_start;
    logic [5:0] best_length;
    logic [7:0] lock_loss_count;
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
    logic       revo_slip;
    int         slip_cnt = 0;
`endif

    logic        auto_pulse;
    logic        man_pulse;
    int          gen_mode;
    int          gen_cnt;
    logic [31:0] good_mask;
    int          checks   = 0;
    int          failures = 0;

    assign revo_pulse = auto_pulse | man_pulse;

    revo_phase_calibration_controller #(
        .TAP_WIDTH(5), .NUM_TAPS(32), .SETTLE_CYCLES(4), .PULSES_PER_TAP(2),
        .EXPECTED_PERIOD(8), .PERIOD_WIDTH(8), .LOCK_STABLE_CYCLES(16), .MIN_GOOD_TAPS(3)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .pll_locked(pll_locked),
        .revo_pulse(revo_pulse),
        .delay_tap(delay_tap),
        .clock_select(clock_select),
        .busy(busy),
        .calibrated(calibrated),
        .error(error),
        .best_start(best_start),
        .best_length(best_length),
`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
        .revo_slip(revo_slip),
`endif
        .lock_loss_count(lock_loss_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Auto revo source: period depends on whether the current tap is in good_mask.
    initial begin
        auto_pulse = 1'b0;
        gen_cnt    = 0;
        forever begin
            @(posedge clock);
            #1;
            if (gen_mode == 1) begin
                gen_cnt++;
                if (gen_cnt >= (good_mask[delay_tap] ? 8 : 9)) begin
                    auto_pulse = 1'b1;
                    gen_cnt    = 0;
                end else begin
                    auto_pulse = 1'b0;
                end
            end else begin
                auto_pulse = 1'b0;
                gen_cnt    = 0;
            end
        end
    end

`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
    initial begin
        forever begin
            @(negedge clock);
            if (revo_slip === 1'b1) slip_cnt++;
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(calibrated || error) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("end_reached", 32'(calibrated | error), 32'd1);
    endtask

    task automatic send_gap(input int g);
        repeat (g - 1) begin
            step();
            man_pulse = 1'b0;
        end
        step();
        man_pulse = 1'b1;
    endtask

    initial begin
        int          n;
        int          t2;
        int          t3;
        logic        busy_drop;
        logic [4:0]  prev_tap;
        logic [4:0]  tap_before;

        reset_n    = 1'b0;
        start      = 1'b0;
        pll_locked = 1'b1;
        man_pulse  = 1'b0;
        gen_mode   = 0;
        good_mask  = 32'h0;
        repeat (3) step();
        @(negedge clock);
        check("rst_delay_tap", 32'(delay_tap), 32'd0);
        check("rst_clock_select", 32'(clock_select), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_calibrated", 32'(calibrated), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_best_start", 32'(best_start), 32'd0);
        check("rst_best_length", 32'(best_length), 32'd0);
        check("rst_lock_loss", 32'(lock_loss_count), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        @(negedge clock);
        check("csel_locked", 32'(clock_select), 32'd0);

        // Scenario 1: good taps 10..17
        good_mask = 32'h0003_FC00;
        gen_mode  = 1;
        pulse_start();
        @(negedge clock);
        check("s1_busy", 32'(busy), 32'd1);
        wait_end(5000);
        check("s1_best_start", 32'(best_start), 32'd10);
        check("s1_best_length", 32'(best_length), 32'd8);
        check("s1_delay_tap", 32'(delay_tap), 32'd13);
        check("s1_calibrated", 32'(calibrated), 32'd1);
        check("s1_busy_low", 32'(busy), 32'd0);

        // Scenario 2a: tie between 2..4 and 20..22 keeps the earliest
        pulse_start();
        good_mask = 32'h0070_001C;
        wait_end(5000);
        check("s2_best_start", 32'(best_start), 32'd2);
        check("s2_best_length", 32'(best_length), 32'd3);
        check("s2_delay_tap", 32'(delay_tap), 32'd3);
        check("s2_calibrated", 32'(calibrated), 32'd1);

        // Scenario 2b: only 30..31 good, window too short
        pulse_start();
        good_mask = 32'hC000_0000;
        wait_end(5000);
        check("s2b_error", 32'(error), 32'd1);
        check("s2b_calibrated", 32'(calibrated), 32'd0);
        check("s2b_delay_tap", 32'(delay_tap), 32'd0);
        check("s2b_best_start", 32'(best_start), 32'd30);
        check("s2b_best_length", 32'(best_length), 32'd2);

        // Scenario 3: no revo at all, every tap times out
        gen_mode = 0;
        pulse_start();
        busy_drop = 1'b0;
        prev_tap  = delay_tap;
        t2 = 0;
        t3 = 0;
        n  = 0;
        while (!error && n < 3000) begin
            @(negedge clock);
            n++;
            if (!busy && !error) busy_drop = 1'b1;
            if (delay_tap != prev_tap) begin
                if (delay_tap == 5'd2) t2 = n;
                if (delay_tap == 5'd3) t3 = n;
                prev_tap = delay_tap;
            end
        end
        check("s3_error", 32'(error), 32'd1);
        check("s3_busy_held", 32'(busy_drop), 32'd0);
        check("s3_tap_period", 32'(t3 - t2), 32'd21);
        check("s3_best_length", 32'(best_length), 32'd0);

        // Scenario 4: lock loss during tap 7 measurement
        good_mask = 32'h0003_FC00;
        gen_mode  = 1;
        pulse_start();
        n = 0;
        while (delay_tap != 5'd7 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("s4_reached_tap7", 32'(delay_tap), 32'd7);
        repeat (6) step();
        pll_locked = 1'b0;
        @(negedge clock);
        check("s4_csel_before", 32'(clock_select), 32'd0);
        step();
        @(negedge clock);
        check("s4_csel_fallback", 32'(clock_select), 32'd1);
        check("s4_lock_loss", 32'(lock_loss_count), 32'd1);
        check("s4_busy", 32'(busy), 32'd1);
        repeat (8) step();
        check("s4_tap_held", 32'(delay_tap), 32'd7);
        step();
        pll_locked = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (delay_tap == 5'd0 && n == 0) n = i;
        end
        check("s4_relock_cycles", 32'(n), 32'd16);
        wait_end(5000);
        check("s4_best_start", 32'(best_start), 32'd10);
        check("s4_best_length", 32'(best_length), 32'd8);
        check("s4_delay_tap", 32'(delay_tap), 32'd13);
        check("s4_lock_loss_final", 32'(lock_loss_count), 32'd1);

        // Scenario 5: reset during EVAL of tap 3 (silent scan, fixed 21-cycle taps)
        gen_mode = 0;
        pulse_start();
        n = 0;
        while (delay_tap != 5'd3 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (20) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("s5_delay_tap", 32'(delay_tap), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_clock_select", 32'(clock_select), 32'd1);
        check("s5_best_start", 32'(best_start), 32'd0);
        check("s5_best_length", 32'(best_length), 32'd0);
        check("s5_lock_loss", 32'(lock_loss_count), 32'd0);
        repeat (30) step();
        check("s5_no_resume", 32'(busy), 32'd0);
        gen_mode = 1;
        pulse_start();
        repeat (300) step();
        tap_before = delay_tap;
        pulse_start();
        repeat (20) step();
        check("s5_start_ignored", 32'(delay_tap >= tap_before && delay_tap != 5'd0), 32'd1);
        wait_end(5000);
        check("s5_best_start_final", 32'(best_start), 32'd10);
        check("s5_delay_tap_final", 32'(delay_tap), 32'd13);

`ifdef REVO_CALIBRATION_CONTINUOUS_MONITOR_EN
        // Scenario 6: slip monitor in DONE
        repeat (40) step();
        check("s6_no_slip_good", 32'(slip_cnt), 32'd0);
        gen_mode = 0;
        send_gap(3);
        send_gap(8);
        repeat (3) send_gap(9);
        send_gap(8);
        repeat (3) send_gap(9);
        step();
        man_pulse = 1'b0;
        repeat (3) step();
        check("s6_three_bad_no_slip", 32'(slip_cnt), 32'd0);
        check("s6_still_calibrated", 32'(calibrated), 32'd1);
        send_gap(9);
        step();
        man_pulse = 1'b0;
        repeat (3) step();
        check("s6_slip_pulse", 32'(slip_cnt), 32'd1);
        check("s6_calibrated_low", 32'(calibrated), 32'd0);
        check("s6_rescan_busy", 32'(busy), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/revo_phase_calibration_controller.md
Name: revo_phase_calibration_controller

Overview:
- Sequences the revo-input delay-tap datapath on the clock/revo receiver board.
- Sweeps the delay tap; for each tap, checks that the recovered revo arrives with the exact expected period; then selects the centre of the longest contiguous good-tap window.
- Tracks PLL lock. Drives the remote/local clock select while the PLL is unlocked, and restarts calibration when lock returns.

Parameters:
- TAP_WIDTH, 5, width of delay_tap
- NUM_TAPS, 32, taps swept: 0..NUM_TAPS-1 (must be ≤ 2**TAP_WIDTH)
- SETTLE_CYCLES, 64, cycles to wait after each tap change
- PULSES_PER_TAP, 8, measured revo periods per tap
- EXPECTED_PERIOD, 1280, required revo period in clock cycles
- PERIOD_WIDTH, 16, period counter width; must hold 2*EXPECTED_PERIOD
- LOCK_STABLE_CYCLES, 256, consecutive pll_locked cycles required before scanning
- MIN_GOOD_TAPS, 3, minimum window length for success

Ports:
- clock, input, 1, recovered system clock; all logic is on its rising edge
- reset_n, input, 1, synchronous active-low reset
- start, input, 1, single-cycle pulse; requests (re)calibration
- pll_locked, input, 1, PLL lock status; already synchronised to clock
- revo_pulse, input, 1, one-cycle strobe per recovered revo
- delay_tap, output, TAP_WIDTH, tap setting to the delay line
- clock_select, output, 1, 1 = local clock fallback, 0 = remote clock
- busy, output, 1, scan in progress (WAIT_LOCK/SETTLE/MEASURE/EVAL)
- calibrated, output, 1, set in DONE
- error, output, 1, set in FAIL
- best_start, output, TAP_WIDTH, first tap of the chosen window
- best_length, output, TAP_WIDTH+1, length of the chosen window
- lock_loss_count, output, 8, saturating count of lock losses while busy or calibrated

Behaviour:
- Reset values:
  - state IDLE; delay_tap 0; clock_select 1; busy 0; calibrated 0; error 0.
  - best_start 0; best_length 0; lock_loss_count 0; all counters 0.
- IDLE:
  - Entered only from reset.
  - start → WAIT_LOCK.
  - clock_select = ~pll_locked, registered (1-cycle latency). This registered rule applies in every state.
- WAIT_LOCK:
  - Counts consecutive pll_locked cycles; a 0 clears the count.
  - On reaching LOCK_STABLE_CYCLES: delay_tap←0, clear run/best trackers → SETTLE.
- SETTLE:
  - Counts SETTLE_CYCLES, ignoring revo_pulse → MEASURE.
  - The period counter and pulse counter are cleared on entry to MEASURE.
- MEASURE:
  - The first revo_pulse arms timing and is not measured.
  - Each later pulse compares period_count with EXPECTED_PERIOD. period_count = cycles since the previous pulse, equal to 1 on the cycle after a pulse.
  - Any mismatch marks the tap bad.
  - After PULSES_PER_TAP measured periods → EVAL.
  - Timeout: period_count (or time waiting for the arming pulse) reaching 2*EXPECTED_PERIOD marks the tap bad → EVAL.
- EVAL (1 cycle):
  - Good tap: extend the current run (run_start set if the run length was 0).
  - Bad tap, or good tap on the last tap: close the run. Replace best only if run length > best_length, so ties keep the earliest run.
  - Runs never wrap from tap NUM_TAPS-1 to 0.
  - If delay_tap < NUM_TAPS-1: delay_tap+1 → SETTLE.
  - Else if best_length ≥ MIN_GOOD_TAPS: delay_tap ← best_start + (best_length-1)>>1 → DONE.
  - Else: delay_tap ← 0 → FAIL.
- DONE:
  - calibrated=1; delay_tap held.
  - start → WAIT_LOCK (calibrated cleared the same cycle).
- FAIL:
  - error=1.
  - start → WAIT_LOCK (error cleared).
- Lock loss:
  - Applies when pll_locked=0 in SETTLE, MEASURE, EVAL or DONE.
  - lock_loss_count+1 (saturates at 255); clears calibrated → WAIT_LOCK.
  - delay_tap is held until the scan restarts at 0.
  - Lock loss in WAIT_LOCK only clears the stability count.
- start while busy: ignored.
- Lock loss and start in the same cycle: lock loss wins.
- reset_n low mid-scan: all outputs return to reset values on the next edge.

Optional Feature:
- Macro: REVO_CALIBRATION_CONTINUOUS_MONITOR_EN.
- Defined:
  - In DONE, keep measuring revo periods.
  - 4 consecutive mismatched or timed-out periods → adds output revo_slip, a 1-cycle pulse, clears calibrated and enters WAIT_LOCK (automatic recalibration).
  - A good period clears the mismatch count.
- Undefined: DONE ignores revo_pulse; there is no revo_slip port.

Test Plan:
1. pll_locked=1 throughout; start; revo period 1280 only for taps 10–17 (bad elsewhere) → after the scan, best_start=10, best_length=8, delay_tap=13, calibrated=1, busy=0.
2. Good taps 2–4 and 20–22 (a tie) → best_start=2, delay_tap=3. Good taps 30–31 only (length 2) → error=1, delay_tap=0.
3. No revo_pulse at all → each tap times out after 2560 cycles → FAIL after 32 taps; busy stays 1 throughout the scan.
4. pll_locked drops for 10 cycles during tap 7 MEASURE → clock_select=1 one cycle later; lock_loss_count=1; the scan restarts at tap 0 only after 256 locked cycles; final result matches scenario 1.
5. reset_n=0 for one cycle during EVAL → all outputs at reset values; start is needed to resume. A start during a scan → no effect.
6. (Macro defined) After DONE, inject periods of 1281 ×4 → revo_slip pulse; calibrated falls; rescan begins. 3 bad periods followed by a good one → no slip.
